switch_event_decoder: RTL and testbench

Gesture decoder for a debounced, clock-synchronous switch level. It turns press/release activity into discrete gesture events: single click, double click, long press and long release. Timing is measured in ticks of the same sampling strobe that drives the debounce filter. It sits between the debounce filter and application logic, and delivers events over a one-entry valid/ready output register.

---
 rtl/switch_input_pkg.sv | 35 +++
 rtl/switch_event_slot.sv | 55 +++++
 rtl/switch_event_decoder.sv | 106 ++++++++++
 tb/tb_switch_event_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/switch_input_pkg.sv
// ============================================================================
// Module  : switch_input_pkg
// Purpose : Shared types for the switch gesture decoder (event codes, FSM states).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package switch_input_pkg;

  typedef enum logic [2:0] {
    EV_NONE         = 3'd0,
    EV_SINGLE_CLICK = 3'd1,
    EV_DOUBLE_CLICK = 3'd2,
    EV_LONG_PRESS   = 3'd3,
    EV_LONG_RELEASE = 3'd4,
    EV_REPEAT       = 3'd5
  } event_code_t;

  typedef enum logic [2:0] {
    ST_IDLE           = 3'd0,
    ST_PRESSED        = 3'd1,
    ST_WAIT_SECOND    = 3'd2,
    ST_SECOND_PRESSED = 3'd3,
    ST_LONG_HELD      = 3'd4
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/switch_event_slot.sv
// ============================================================================
// Module  : switch_event_slot
// Purpose : One-entry valid/ready event register; drops new events when full.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_event_slot
  import switch_input_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push_i,
  input  event_code_t code_i,
  input  logic        ready_i,
  output logic        valid_o,
  output event_code_t code_o,
  output logic        overflow_o
);

  logic        valid_q;
  event_code_t code_q;
  logic        overflow_q;
  logic        accept;

  assign accept = valid_q && ready_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q    <= 1'b0;
      code_q     <= EV_NONE;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (push_i) begin
        // A slot being drained this cycle can take the new event directly.
        if (!valid_q || accept) begin
          valid_q <= 1'b1;
          code_q  <= code_i;
        end else begin
          overflow_q <= 1'b1;
        end
      end else if (accept) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o    = valid_q;
  assign code_o     = code_q;
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: rtl/switch_event_decoder.sv
// ============================================================================
// Module  : switch_event_decoder
// Purpose : Click / double-click / long-press gesture decoder; auto-repeat in
//           LONG_HELD is enabled by defining SWITCH_EVENT_REPEAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_event_decoder
  import switch_input_pkg::*;
#(
  parameter int LONG_PRESS_TICKS   = 100,
  parameter int DOUBLE_CLICK_TICKS = 30,
  parameter int REPEAT_TICKS       = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        level_in,
  output logic        event_valid,
  input  logic        event_ready,
  output event_code_t event_code,
  output logic        event_overflow
);

`ifdef SWITCH_EVENT_REPEAT_EN
  localparam logic REPEAT_EN = 1'b1;
  localparam int   MAX_TICKS = max3(LONG_PRESS_TICKS, DOUBLE_CLICK_TICKS, REPEAT_TICKS);
`else
  localparam logic REPEAT_EN = 1'b0;
  localparam int   MAX_TICKS = max3(LONG_PRESS_TICKS, DOUBLE_CLICK_TICKS, 1);
`endif
  localparam int CW = $clog2(MAX_TICKS + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d, count_inc;
  logic          level_q;
  logic          rise, fall;
  logic          long_hit, dbl_hit, rep_hit;
  logic          push;
  event_code_t   push_code;

  assign rise      = level_in && !level_q;
  assign fall      = !level_in && level_q;
  assign count_inc = (count_q == {CW{1'b1}}) ? count_q : count_q + 1'b1;
  assign long_hit  = tick && (count_inc == CW'(LONG_PRESS_TICKS));
  assign dbl_hit   = tick && (count_inc == CW'(DOUBLE_CLICK_TICKS));
  assign rep_hit   = REPEAT_EN && tick && (count_inc == CW'(REPEAT_TICKS));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      level_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      level_q <= level_in;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = tick ? count_inc : count_q;
    case (state_q)
      ST_IDLE:           if (rise) state_d = ST_PRESSED;
      ST_PRESSED:        if (fall) state_d = ST_WAIT_SECOND;
                         else if (long_hit) state_d = ST_LONG_HELD;
      ST_WAIT_SECOND:    if (rise) state_d = ST_SECOND_PRESSED;
                         else if (dbl_hit) state_d = ST_IDLE;
      ST_SECOND_PRESSED: if (fall) state_d = ST_IDLE;
      ST_LONG_HELD:      if (fall) state_d = ST_IDLE;
                         else if (rep_hit) count_d = '0;
      default:           state_d = ST_IDLE;
    endcase
    if (state_d != state_q) count_d = '0;
  end

  // Edges take priority over tick thresholds in every state.
  always_comb begin
    push      = 1'b0;
    push_code = EV_NONE;
    case (state_q)
      ST_PRESSED:        if (!fall && long_hit) begin push = 1'b1; push_code = EV_LONG_PRESS; end
      ST_WAIT_SECOND:    if (!rise && dbl_hit) begin push = 1'b1; push_code = EV_SINGLE_CLICK; end
      ST_SECOND_PRESSED: if (fall) begin push = 1'b1; push_code = EV_DOUBLE_CLICK; end
      ST_LONG_HELD:      if (fall) begin push = 1'b1; push_code = EV_LONG_RELEASE; end
                         else if (rep_hit) begin push = 1'b1; push_code = EV_REPEAT; end
      default:           ;
    endcase
  end

  switch_event_slot u_slot (
    .clock      (clock),
    .reset      (reset),
    .push_i     (push),
    .code_i     (push_code),
    .ready_i    (event_ready),
    .valid_o    (event_valid),
    .code_o     (event_code),
    .overflow_o (event_overflow)
  );

endmodule

`default_nettype wire

// File: tb/tb_switch_event_decoder.sv
// ============================================================================
// Module  : tb_switch_event_decoder
// Purpose : Self-checking bench: gesture-level reference model plus directed cases.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_event_decoder;

  localparam int LPT = 10;
  localparam int DCT = 4;
  localparam int RPT = 3;
`ifdef SWITCH_EVENT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       level_in;
  logic       event_valid;
  logic       event_ready;
  logic [2:0] event_code;
  logic       event_overflow;

  int n_checks = 0;
  int n_pass   = 0;
  int acc[8];
  int ovf_n;

  switch_event_decoder #(
    .LONG_PRESS_TICKS   (LPT),
    .DOUBLE_CLICK_TICKS (DCT),
    .REPEAT_TICKS       (RPT)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .tick           (tick),
    .level_in       (level_in),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_code     (event_code),
    .event_overflow (event_overflow)
  );

  always #5 clock = ~clock;

  // Reference model: gesture phase + ticks elapsed in that phase, and a one-deep slot.
  int       m_phase;   // 0 idle, 1 pressed, 2 waiting for second, 3 second press, 4 long held
  int       m_ticks;
  bit       m_prev;
  bit       m_valid;
  int       m_code;
  bit       m_ovf;

  always @(posedge clock) begin
    bit r, f, acc_now;
    int ev, t;
    if (reset) begin
      m_phase = 0; m_ticks = 0; m_prev = 1'b1;
      m_valid = 1'b0; m_code = 0; m_ovf = 1'b0;
    end else begin
      r  = level_in && !m_prev;
      f  = !level_in && m_prev;
      ev = 0;
      t  = tick ? m_ticks + 1 : m_ticks;
      case (m_phase)
        0: begin if (r) begin m_phase = 1; t = 0; end end
        1: begin
          if (f) begin m_phase = 2; t = 0; end
          else if (tick && t == LPT) begin ev = 3; m_phase = 4; t = 0; end
        end
        2: begin
          if (r) begin m_phase = 3; t = 0; end
          else if (tick && t == DCT) begin ev = 1; m_phase = 0; t = 0; end
        end
        3: begin if (f) begin ev = 2; m_phase = 0; t = 0; end end
        default: begin
          if (f) begin ev = 4; m_phase = 0; t = 0; end
          else if (REP && tick && t == RPT) begin ev = 5; t = 0; end
        end
      endcase
      m_ticks = t;
      m_prev  = level_in;
      acc_now = m_valid && event_ready;
      m_ovf   = 1'b0;
      if (ev != 0) begin
        if (!m_valid || acc_now) begin m_valid = 1'b1; m_code = ev; end
        else m_ovf = 1'b1;
      end else if (acc_now) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle compare plus tally of accepted events.
  always @(negedge clock) begin
    if (!reset) begin
      n_checks++;
      if (event_valid === m_valid && event_code === 3'(m_code) && event_overflow === m_ovf)
        n_pass++;
      else
        $display("FAIL cycle_compare t=%0t actual valid=%0b code=%0d ovf=%0b required valid=%0b code=%0d ovf=%0b",
                 $time, event_valid, event_code, event_overflow, m_valid, m_code, m_ovf);
      if (event_valid && event_ready) acc[event_code]++;
      if (event_overflow) ovf_n++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic step(input bit t);
    tick = t;
    @(posedge clock);
    #1;
    tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) begin step(0); step(0); step(0); step(1); end
  endtask

  task automatic clr_counts();
    foreach (acc[i]) acc[i] = 0;
    ovf_n = 0;
  endtask

  int run;

  initial begin
    reset = 1'b1; level_in = 1'b0; tick = 1'b0; event_ready = 1'b1;
    clr_counts();
    repeat (3) step(0);
    check("reset_valid", int'(event_valid), 0);
    check("reset_code", int'(event_code), 0);
    check("reset_ovf", int'(event_overflow), 0);
    reset = 1'b0;
    step(0);

    // Single click: valid appears right after the 4th tick following release.
    clr_counts();
    level_in = 1'b1; ticks(3);
    level_in = 1'b0; ticks(4);
    check("single_latency_valid", int'(event_valid), 1);
    check("single_latency_code", int'(event_code), 1);
    ticks(3);
    check("single_count", acc[1], 1);
    check("single_no_other", acc[2] + acc[3] + acc[4] + acc[5], 0);

    // Double click.
    clr_counts();
    level_in = 1'b1; ticks(2);
    level_in = 1'b0; ticks(2);
    level_in = 1'b1; ticks(2);
    level_in = 1'b0; step(0);
    check("double_latency_valid", int'(event_valid), 1);
    check("double_latency_code", int'(event_code), 2);
    ticks(6);
    check("double_count", acc[2], 1);
    check("double_no_single", acc[1], 0);

    // Long press / release, with repeats when the feature is built in.
    clr_counts();
    level_in = 1'b1; ticks(REP ? 17 : 15);
    level_in = 1'b0; ticks(6);
    check("long_press", acc[3], 1);
    check("long_release", acc[4], 1);
    check("long_repeat", acc[5], REP ? 2 : 0);
    check("long_no_click", acc[1] + acc[2], 0);

    // Back-pressure: LONG_RELEASE dropped while LONG_PRESS waits.
    clr_counts();
    event_ready = 1'b0;
    level_in = 1'b1; ticks(11);
    level_in = 1'b0; ticks(1);
    check("bp_held_code", int'(event_code), 3);
    event_ready = 1'b1;
    ticks(6);
    check("bp_accept_lp", acc[3], 1);
    check("bp_lost_lr", acc[4], 0);
    check("bp_overflow_pulses", ovf_n, 1);

    // Level held through reset produces nothing until re-pressed.
    clr_counts();
    level_in = 1'b1; reset = 1'b1; step(0); step(0); reset = 1'b0;
    ticks(20);
    level_in = 1'b0; ticks(2);
    check("held_reset_silent", acc[1] + acc[2] + acc[3] + acc[4] + acc[5], 0);
    level_in = 1'b1; ticks(2);
    level_in = 1'b0; ticks(6);
    check("held_reset_then_click", acc[1], 1);

    // Second release coinciding with the 4th tick after first release.
    clr_counts();
    level_in = 1'b1; ticks(1);
    level_in = 1'b0; ticks(3); step(0); step(0);
    level_in = 1'b1; step(0);
    level_in = 1'b0; step(1);
    ticks(6);
    check("edge_tick_double", acc[2], 1);
    check("edge_tick_no_single", acc[1], 0);

    // Rise coinciding with the timeout tick in the wait window.
    clr_counts();
    level_in = 1'b1; ticks(1);
    level_in = 1'b0; ticks(3); step(0); step(0); step(0);
    level_in = 1'b1; step(1);
    ticks(1);
    level_in = 1'b0; ticks(6);
    check("rise_beats_tick_double", acc[2], 1);
    check("rise_beats_tick_no_single", acc[1], 0);

    // Randomized traffic against the model.
    run = 0;
    for (int i = 0; i < 6000; i++) begin
      if (run == 0) begin
        level_in = ~level_in;
        run = $urandom_range(1, 70);
      end
      run--;
      event_ready = ($urandom_range(0, 4) != 0);
      reset = ($urandom_range(0, 1499) == 0);
      step($urandom_range(0, 3) == 0);
      reset = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
